muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle controller and iterative datapath for the type A
//   multiply/divide instructions. Operands are signed; the core works on
//   magnitudes (shift-add multiply, restoring divide) and applies the sign
//   correction in a final FIXUP cycle. The double-width result feeds the
//   dual register write: low half to rd, high half to hi/remainder.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          synchronous active-high reset
//   start_i      request a new operation (honoured in IDLE or DONE only)
//   isDiv_i      0 = multiply, 1 = divide (sampled with start_i)
//   opA_i        signed multiplicand / dividend (sampled with start_i)
//   opB_i        signed multiplier / divisor (sampled with start_i)
//   flush_i      abandon an in-flight operation (branch/jump squash)
//   stall_o      freeze upstream pipeline stages
//   done_o       one-cycle pulse, result valid / dual write-back enable
//   resultLo_o   product low half or quotient
//   resultHi_o   product high half or remainder
//   divByZero_o  divide with a zero divisor, valid with done_o
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             isDiv_i,
  input  logic [WIDTH-1:0] opA_i,
  input  logic [WIDTH-1:0] opB_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] resultLo_o,
  output logic [WIDTH-1:0] resultHi_o,
  output logic             divByZero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opMag_q, opMag_d;
  logic             isDiv_q, isDiv_d;
  logic             negLo_q, negLo_d;
  logic             negHi_q, negHi_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] resLo_q, resLo_d;
  logic [WIDTH-1:0] resHi_q, resHi_d;
  logic             resDbz_q, resDbz_d;

  logic             accept;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divTake;
  logic [2*WIDTH-1:0] prodNeg;
  logic [WIDTH-1:0] quoNeg, remNeg;

  assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));

  assign magA = opA_i[WIDTH-1] ? -opA_i : opA_i;
  assign magB = opB_i[WIDTH-1] ? -opB_i : opB_i;

  // hi/lo double as {accumulator, multiplier} for multiply and as
  // {partial remainder, dividend/quotient} for divide.
  assign mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opMag_q} : '0);
  assign divShift = {hi_q, lo_q[WIDTH-1]};
  assign divTake  = (divShift >= {1'b0, opMag_q});

  assign prodNeg = -{hi_q, lo_q};
  assign quoNeg  = -lo_q;
  assign remNeg  = -hi_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush outranks the RUN->FIXUP exit, start outranks
  // flush in IDLE/DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = RUN;
      RUN: begin
        if (flush_i)             state_d = IDLE;
        else if (count_q == '0)  state_d = FIXUP;
      end
      FIXUP: state_d = flush_i ? IDLE : DONE;
      DONE:  state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; stall rises combinationally in the cycle start is accepted.
  always_comb begin
    stall_o = (state_q == RUN) || (state_q == FIXUP) || accept;
    done_o  = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opMag_d   = opMag_q;
    isDiv_d   = isDiv_q;
    negLo_d   = negLo_q;
    negHi_d   = negHi_q;
    divZero_d = divZero_q;
    resLo_d   = resLo_q;
    resHi_d   = resHi_q;
    resDbz_d  = resDbz_q;
    if (accept) begin
      isDiv_d   = isDiv_i;
      count_d   = CW'(WIDTH - 1);
      hi_d      = '0;
      negLo_d   = opA_i[WIDTH-1] ^ opB_i[WIDTH-1];
      negHi_d   = opA_i[WIDTH-1];
      divZero_d = isDiv_i && (opB_i == '0);
      if (isDiv_i) begin
        lo_d    = magA;
        opMag_d = magB;
      end else begin
        lo_d    = magB;
        opMag_d = magA;
      end
    end else if ((state_q == RUN) && !flush_i) begin
      count_d = count_q - 1'b1;
      if (isDiv_q) begin
        hi_d = divTake ? WIDTH'(divShift - {1'b0, opMag_q}) : divShift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], divTake};
      end else begin
        hi_d = mulSum[WIDTH:1];
        lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
      end
    end else if ((state_q == FIXUP) && !flush_i) begin
      resDbz_d = divZero_q;
      if (isDiv_q) begin
        // A zero divisor leaves the remainder equal to |dividend|, so the
        // remainder sign fix restores the original dividend on its own.
        resLo_d = divZero_q ? '1 : (negLo_q ? quoNeg : lo_q);
        resHi_d = negHi_q ? remNeg : hi_q;
      end else begin
        {resHi_d, resLo_d} = negLo_q ? prodNeg : {hi_q, lo_q};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opMag_q   <= '0;
      isDiv_q   <= 1'b0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
      divZero_q <= 1'b0;
      resLo_q   <= '0;
      resHi_q   <= '0;
      resDbz_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opMag_q   <= opMag_d;
      isDiv_q   <= isDiv_d;
      negLo_q   <= negLo_d;
      negHi_q   <= negHi_d;
      divZero_q <= divZero_d;
      resLo_q   <= resLo_d;
      resHi_q   <= resHi_d;
      resDbz_q  <= resDbz_d;
    end
  end

  assign resultLo_o  = resLo_q;
  assign resultHi_o  = resHi_q;
  assign divByZero_o = resDbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed plus random checks of muldiv_sequencer (WIDTH = 16). Expected
//   results come from signed integer arithmetic on the operands; timing
//   expectations are the fixed 18-cycle stall / done latency.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, isDiv, flush;
  logic [W-1:0] opA, opB;
  logic         stall, done, dbz;
  logic [W-1:0] resLo, resHi;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pendLo, pendHi, lastLo, lastHi;
  logic         pendDbz, lastDbz;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .isDiv_i    (isDiv),
    .opA_i      (opA),
    .opB_i      (opB),
    .flush_i    (flush),
    .stall_o    (stall),
    .done_o     (done),
    .resultLo_o (resLo),
    .resultHi_o (resHi),
    .divByZero_o(dbz)
  );

  always #5 clk = ~clk;

  // Signed reference: multiply is the full product, divide is truncating
  // with remainder following the dividend; zero divisor gives all ones and
  // the dividend back.
  function automatic void model(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic z);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    if (!div) begin
      p  = sa * sb;
      lo = p[W-1:0];
      hi = p[2*W-1:W];
    end else if (b == '0) begin
      lo = '1;
      hi = a;
      z  = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic div, input logic [W-1:0] a, input logic [W-1:0] b);
    isDiv = div;
    opA   = a;
    opB   = b;
    start = 1'b1;
    model(div, a, b, pendLo, pendHi, pendDbz);
    #1;
    checkOutput("stall_on_start", 32'(stall), 32'd1);
  endtask

  // Waits for done from the cycle start was presented; optionally keeps
  // start high with different operands during RUN.
  task automatic waitForDone(input string tag, input bit holdStart,
                             input logic [W-1:0] altA, input logic [W-1:0] altB);
    int lat = 0;
    int stalls = 1;
    bit seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      tick();
      if (cyc == 1) begin
        flush = 1'b0;
        if (holdStart) begin
          opA = altA;
          opB = altB;
        end else begin
          start = 1'b0;
        end
      end
      if (cyc == 10) start = 1'b0;
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc;
      end else if (stall) begin
        stalls++;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_latency"}, 32'(lat), 32'd18);
      checkOutput({tag, "_stall_cycles"}, 32'(stalls), 32'd18);
      checkOutput({tag, "_lo"}, 32'(resLo), 32'(pendLo));
      checkOutput({tag, "_hi"}, 32'(resHi), 32'(pendHi));
      checkOutput({tag, "_dbz"}, 32'(dbz), 32'(pendDbz));
      lastLo  = pendLo;
      lastHi  = pendHi;
      lastDbz = pendDbz;
    end
  endtask

  task automatic checkHeld(input string tag);
    tick();
    checkOutput({tag, "_done_low"}, 32'(done), 32'd0);
    checkOutput({tag, "_stall_low"}, 32'(stall), 32'd0);
    checkOutput({tag, "_held_lo"}, 32'(resLo), 32'(lastLo));
    checkOutput({tag, "_held_hi"}, 32'(resHi), 32'(lastHi));
    checkOutput({tag, "_held_dbz"}, 32'(dbz), 32'(lastDbz));
  endtask

  task automatic runOp(input string tag, input logic div, input logic [W-1:0] a, input logic [W-1:0] b);
    applyStimulus(div, a, b);
    waitForDone(tag, 1'b0, '0, '0);
    checkHeld(tag);
  endtask

  // Counts done pulses over a window where none may appear.
  task automatic expectQuiet(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) pulses++;
    end
    checkOutput({tag, "_no_done"}, 32'(pulses), 32'd0);
  endtask

  task automatic flushAfter(input string tag, input int ticks);
    applyStimulus(1'b0, W'($urandom), W'($urandom));
    for (int i = 0; i < ticks; i++) begin
      tick();
      start = 1'b0;
    end
    checkOutput({tag, "_busy_before_flush"}, 32'(stall), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checkOutput({tag, "_stall_after_flush"}, 32'(stall), 32'd0);
    checkOutput({tag, "_done_after_flush"}, 32'(done), 32'd0);
    expectQuiet(tag, 25);
    checkOutput({tag, "_held_lo"}, 32'(resLo), 32'(lastLo));
    checkOutput({tag, "_held_hi"}, 32'(resHi), 32'(lastHi));
    checkOutput({tag, "_held_dbz"}, 32'(dbz), 32'(lastDbz));
  endtask

  initial begin
    logic         rDiv;
    logic [W-1:0] rA, rB;

    rst   = 1'b1;
    start = 1'b0;
    isDiv = 1'b0;
    flush = 1'b0;
    opA   = '0;
    opB   = '0;
    lastLo  = '0;
    lastHi  = '0;
    lastDbz = 1'b0;

    $display("[TB] reset");
    tick();
    tick();
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_lo", 32'(resLo), 32'd0);
    checkOutput("reset_hi", 32'(resHi), 32'd0);
    checkOutput("reset_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] directed multiply / divide");
    runOp("mul_7_m3", 1'b0, 16'h0007, 16'hFFFD);
    runOp("mul_max_max", 1'b0, 16'h7FFF, 16'h7FFF);
    runOp("mul_min_min", 1'b0, 16'h8000, 16'h8000);
    runOp("div_m7_2", 1'b1, 16'hFFF9, 16'h0002);
    runOp("div_overflow", 1'b1, 16'h8000, 16'hFFFF);
    runOp("div_by_zero", 1'b1, 16'h0064, 16'h0000);
    runOp("div_neg_by_zero", 1'b1, 16'h8000, 16'h0000);
    runOp("div_7_m2", 1'b1, 16'h0007, 16'hFFFE);

    $display("[TB] start held during RUN");
    applyStimulus(1'b0, 16'h1234, 16'h0056);
    waitForDone("hold_start", 1'b1, 16'h7FFF, 16'h8000);
    checkHeld("hold_start");

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 16'hFF9C, 16'h0007);
    waitForDone("b2b_first", 1'b0, '0, '0);
    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
    waitForDone("b2b_second", 1'b0, '0, '0);
    checkHeld("b2b_second");

    $display("[TB] flush");
    flushAfter("flush_run5", 5);
    flushAfter("flush_last_iter", 16);
    flushAfter("flush_fixup", 17);

    $display("[TB] start with flush in IDLE");
    applyStimulus(1'b1, 16'h0100, 16'hFFF0);
    flush = 1'b1;
    waitForDone("start_over_flush", 1'b0, '0, '0);
    checkHeld("start_over_flush");

    $display("[TB] random operations");
    for (int n = 0; n < 24; n++) begin
      rDiv = 1'($urandom_range(0, 1));
      rA   = W'($urandom);
      rB   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      runOp("random", rDiv, rA, rB);
    end

    $display("[TB] reset mid-RUN");
    applyStimulus(1'b0, 16'h00FF, 16'h00FF);
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_stall", 32'(stall), 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    checkOutput("rst_mid_lo", 32'(resLo), 32'd0);
    checkOutput("rst_mid_hi", 32'(resHi), 32'd0);
    checkOutput("rst_mid_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    expectQuiet("rst_mid", 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
